// File: rtl/spi_register_controller.sv
// -----------------------------------------------------------------------------
// spi_register_controller
//
// Command sequencer sitting between an SPI slave (SCLK domain) and a register
// file (CLK domain). One SPI transaction is a command byte followed by any
// number of data bytes:
//   command byte : bit 7 = 1 write / 0 read, bits 6:0 = start register address
//   data bytes   : written to, or read from, consecutive registers
//
// The slave's byte-complete strobe and chip select are brought into the CLK
// domain with 2-flop synchronizers and edge-detected. For reads, the register
// at the current address is fetched right after each byte boundary and placed
// on TXByte so the slave can shift it out during the following byte.
//
// Ports
//   CLK        system clock, at least 8x SCLK
//   _RST       asynchronous active-low reset
//   _CS        raw SPI chip select (active-low), asynchronous to CLK
//   ByteDone   slave byte-complete strobe, asynchronous to CLK
//   RXByte     byte received by the slave (stable well past ByteDone)
//   TXByte     byte for the slave to shift out next
//   RegAddr    register file address
//   RegWrData  register write data
//   RegWrEn    one-CLK register write strobe
//   RegRdEn    one-CLK register read strobe (RegRdData valid same cycle)
//   RegRdData  register file read data
//   Busy       high while a (synchronized) chip select is active
//   ErrFlag    sticky flag: an out-of-range register was accessed
// -----------------------------------------------------------------------------
module spi_register_controller #(
    parameter int         NUM_REGS    = 16,
    parameter int         ADDR_WIDTH  = 7,
    parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
    input  logic                  CLK,
    input  logic                  _RST,
    input  logic                  _CS,
    input  logic                  ByteDone,
    input  logic [7:0]            RXByte,
    output logic [7:0]            TXByte,
    output logic [ADDR_WIDTH-1:0] RegAddr,
    output logic [7:0]            RegWrData,
    output logic                  RegWrEn,
    output logic                  RegRdEn,
    input  logic [7:0]            RegRdData,
    output logic                  Busy,
    output logic                  ErrFlag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // -------------------------------------------------------------------------
    // Synchronizers and edge detectors
    // -------------------------------------------------------------------------
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic bd_meta_q, bd_sync_q, bd_prev_q;
    logic cs_fall;
    logic cs_rise;
    logic byte_edge;

    // Chip select idles high, so its flops come out of reset at 1; otherwise
    // the first cycles after reset would look like a chip-select fall.
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            cs_prev_q <= 1'b1;
            bd_meta_q <= 1'b0;
            bd_sync_q <= 1'b0;
            bd_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the value
            // from before this edge, which is what turns this into a shift
            // chain instead of a single flop.
            cs_meta_q <= _CS;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
            bd_meta_q <= ByteDone;
            bd_sync_q <= bd_meta_q;
            bd_prev_q <= bd_sync_q;
        end
    end

    assign cs_fall   = cs_prev_q & ~cs_sync_q;
    assign cs_rise   = ~cs_prev_q & cs_sync_q;
    // RXByte is used directly on this cycle: the slave holds it for a full
    // SCLK bit after ByteDone, far longer than the synchronizer delay.
    assign byte_edge = bd_sync_q & ~bd_prev_q;

    // -------------------------------------------------------------------------
    // Address helpers
    // -------------------------------------------------------------------------
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} < (ADDR_WIDTH + 1)'(NUM_REGS);
    endfunction

    // Inside the register window the address wraps at the top of the window;
    // an explicit out-of-range start simply counts up to the ADDR_WIDTH
    // overflow.
    function automatic logic [ADDR_WIDTH-1:0] addr_next(input logic [ADDR_WIDTH-1:0] addr);
        if ({1'b0, addr} == (ADDR_WIDTH + 1)'(NUM_REGS - 1)) begin
            return '0;
        end
        return addr + ADDR_WIDTH'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Output / datapath registers
    // -------------------------------------------------------------------------
    logic [7:0]            tx_q,      tx_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  wr_en_q,   wr_en_d;
    logic                  rd_en_q,   rd_en_d;
    logic                  busy_q,    busy_d;
    logic                  err_q,     err_d;

    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] cmd_addr;

    assign addr_inc = addr_next(addr_q);
    assign cmd_addr = ADDR_WIDTH'(RXByte[6:0]);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default first means every path drives state_d,
        // so no latch is inferred when a branch leaves it untouched.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (byte_edge) begin
                    state_d = RXByte[7] ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE, ST_READ: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath logic
    // -------------------------------------------------------------------------
    logic                  pf_req;
    logic [ADDR_WIDTH-1:0] pf_addr;

    always_comb begin
        tx_d      = tx_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        busy_d    = busy_q;
        err_d     = err_q;
        pf_req    = 1'b0;
        pf_addr   = addr_q;

        // A write strobe is presented with the address it belongs to, so the
        // auto-increment for writes happens on the cycle after the strobe.
        if (wr_en_q) begin
            addr_d = addr_inc;
        end

        // Second half of a prefetch: the register file answered during the
        // strobe cycle, capture it for the slave.
        if (rd_en_q) begin
            tx_d = RegRdData;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                end
            end
            ST_CMD: begin
                if (byte_edge) begin
                    addr_d = cmd_addr;
                    if (!RXByte[7]) begin
                        pf_req  = 1'b1;
                        pf_addr = cmd_addr;
                    end
                end
            end
            ST_WRITE: begin
                if (byte_edge) begin
                    if (in_range(addr_q)) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = RXByte;
                    end else begin
                        err_d  = 1'b1;
                        addr_d = addr_inc;
                    end
                end
            end
            ST_READ: begin
                if (byte_edge) begin
                    addr_d  = addr_inc;
                    pf_req  = 1'b1;
                    pf_addr = addr_inc;
                end
            end
            default: ;
        endcase

        // First half of a prefetch: strobe the register file at the new
        // address, or report the miss and hand the slave a zero byte.
        if (pf_req) begin
            if (in_range(pf_addr)) begin
                rd_en_d = 1'b1;
            end else begin
                tx_d  = 8'h00;
                err_d = 1'b1;
            end
        end

        // End of transaction. A byte arriving on this same cycle has already
        // been handled above (a write strobe survives); a read strobe is
        // dropped because its data would never be shifted out.
        if (state_q != ST_IDLE && cs_rise) begin
            busy_d  = 1'b0;
            tx_d    = STATUS_BYTE;
            rd_en_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            tx_q      <= STATUS_BYTE;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign TXByte    = tx_q;
    assign RegAddr   = addr_q;
    assign RegWrData = wr_data_q;
    assign RegWrEn   = wr_en_q;
    assign RegRdEn   = rd_en_q;
    assign Busy      = busy_q;
    assign ErrFlag   = err_q;

endmodule

// File: tb/tb_spi_register_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_register_controller
//
// Emulates the SPI slave (ByteDone / RXByte / chip select) and a 16-entry
// register file around spi_register_controller. Directed scenarios use
// expected values worked out by hand; the random scenario predicts each
// transaction from the command/address rules with a simple array model.
// -----------------------------------------------------------------------------
module tb_spi_register_controller;

    localparam int         NUM_REGS = 16;
    localparam logic [7:0] STATUS   = 8'hA5;

    typedef logic [7:0] bytes_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic [6:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data;
    logic       busy;
    logic       err_flag;

    always #5 clk = ~clk;

    spi_register_controller #(
        .NUM_REGS    (NUM_REGS),
        .ADDR_WIDTH  (7),
        .STATUS_BYTE (STATUS)
    ) dut (
        .CLK       (clk),
        ._RST      (rst_n),
        ._CS       (cs_n),
        .ByteDone  (byte_done),
        .RXByte    (rx_byte),
        .TXByte    (tx_byte),
        .RegAddr   (reg_addr),
        .RegWrData (reg_wr_data),
        .RegWrEn   (reg_wr_en),
        .RegRdEn   (reg_rd_en),
        .RegRdData (reg_rd_data),
        .Busy      (busy),
        .ErrFlag   (err_flag)
    );

    // Register file behind the controller: asynchronous read.
    logic [7:0] regfile    [NUM_REGS];
    logic [7:0] model_regs [NUM_REGS];

    assign reg_rd_data = (reg_addr < 7'(NUM_REGS)) ? regfile[reg_addr[3:0]] : 8'h00;

    int          checks      = 0;
    int          passes      = 0;
    int          overlap_cnt = 0;
    logic [14:0] wr_log[$];     // {addr, data} of every RegWrEn pulse
    logic [6:0]  rd_log[$];     // addr of every RegRdEn pulse
    logic [7:0]  obs_recv[$];   // bytes the master would receive
    int          busy_lat;
    logic        busy_mid;
    logic        err_mid;

    // One clock step: observe strobes on the falling edge, apply register
    // writes, then return just after the rising edge where inputs are driven.
    task automatic tick();
        @(negedge clk);
        if (reg_wr_en) begin
            wr_log.push_back({reg_addr, reg_wr_data});
            if (reg_addr < 7'(NUM_REGS)) regfile[reg_addr[3:0]] = reg_wr_data;
        end
        if (reg_rd_en) rd_log.push_back(reg_addr);
        if (reg_wr_en && reg_rd_en) overlap_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One SPI byte: the master captures TXByte as shifting starts, the byte
    // takes 16 CLK to shift in, then ByteDone pulses for 6 CLK.
    task automatic send_byte(input logic [7:0] b);
        obs_recv.push_back(tx_byte);
        rx_byte = b;
        ticks(16);
        byte_done = 1'b1;
        ticks(6);
        byte_done = 1'b0;
        ticks(6);
    endtask

    task automatic end_txn();
        cs_n = 1'b1;
        busy_lat = 0;
        while (busy && busy_lat < 10) begin
            tick();
            busy_lat++;
        end
        ticks(4);
    endtask

    task automatic run_txn(input bytes_t q);
        obs_recv.delete();
        wr_log.delete();
        rd_log.delete();
        cs_n = 1'b0;
        ticks(6);
        busy_mid = busy;
        err_mid  = err_flag;
        foreach (q[i]) send_byte(q[i]);
        end_txn();
    endtask

    function automatic logic [6:0] model_next(input logic [6:0] a);
        if (int'(a) == NUM_REGS - 1) return 7'd0;
        return 7'((int'(a) + 1) % 128);
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset();
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                // Start a read of register 5 and pull reset mid-data-byte.
                rst_n = 1'b1;
                ticks(3);
                cs_n = 1'b0;
                ticks(6);
                send_byte(8'h05);
                rx_byte = 8'hEE;
                ticks(8);
                rst_n = 1'b0;
                #2;
            end
            checks++; if (tx_byte !== STATUS) $display("FAIL reset%0d_tx: got %h expected %h", phase, tx_byte, STATUS); else passes++;
            checks++; if (reg_addr !== 7'd0) $display("FAIL reset%0d_addr: got %h expected 00", phase, reg_addr); else passes++;
            checks++; if (reg_wr_data !== 8'h00) $display("FAIL reset%0d_wrdata: got %h expected 00", phase, reg_wr_data); else passes++;
            checks++; if (reg_wr_en !== 1'b0 || reg_rd_en !== 1'b0) $display("FAIL reset%0d_strobes: got wr=%b rd=%b expected 0 0", phase, reg_wr_en, reg_rd_en); else passes++;
            checks++; if (busy !== 1'b0) $display("FAIL reset%0d_busy: got %b expected 0", phase, busy); else passes++;
            checks++; if (err_flag !== 1'b0) $display("FAIL reset%0d_err: got %b expected 0", phase, err_flag); else passes++;
        end
        cs_n = 1'b1;
        byte_done = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        wr_log.delete();
        rd_log.delete();
        ticks(12);
        checks++; if (wr_log.size() + rd_log.size() != 0) $display("FAIL reset_release_strobes: got %0d pulses expected 0", wr_log.size() + rd_log.size()); else passes++;
        checks++; if (busy !== 1'b0 || tx_byte !== STATUS) $display("FAIL reset_release_idle: got busy=%b tx=%h expected 0 a5", busy, tx_byte); else passes++;
    endtask

    task automatic test_single_write();
        bytes_t q;
        q = {8'h83, 8'h5C};
        run_txn(q);
        checks++; if (busy_mid !== 1'b1) $display("FAIL single_busy_high: got %b expected 1", busy_mid); else passes++;
        checks++; if (wr_log.size() != 1) $display("FAIL single_wr_count: got %0d expected 1", wr_log.size()); else passes++;
        checks++; if (wr_log[0] !== {7'd3, 8'h5C}) $display("FAIL single_wr: got %h expected %h", wr_log[0], {7'd3, 8'h5C}); else passes++;
        checks++; if (rd_log.size() != 0) $display("FAIL single_no_read: got %0d expected 0", rd_log.size()); else passes++;
        checks++; if (busy_lat < 2 || busy_lat > 3) $display("FAIL single_busy_fall: got %0d clk expected 2..3", busy_lat); else passes++;
        checks++; if (err_flag !== 1'b0) $display("FAIL single_err: got %b expected 0", err_flag); else passes++;
    endtask

    task automatic test_burst_wrap();
        bytes_t q;
        logic [14:0] exp_wr [3];
        q = {8'h8E, 8'h11, 8'h22, 8'h33};
        exp_wr = '{{7'd14, 8'h11}, {7'd15, 8'h22}, {7'd0, 8'h33}};
        run_txn(q);
        checks++; if (wr_log.size() != 3) $display("FAIL burst_wr_count: got %0d expected 3", wr_log.size()); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (wr_log[i] !== exp_wr[i]) $display("FAIL burst_wr%0d: got %h expected %h", i, wr_log[i], exp_wr[i]); else passes++;
        end
        checks++; if (err_flag !== 1'b0) $display("FAIL burst_err: got %b expected 0", err_flag); else passes++;
    endtask

    task automatic test_read();
        bytes_t q;
        logic [7:0] exp_rx [3];
        regfile[5] = 8'hC7;
        regfile[6] = 8'h3A;
        q = {8'h05, 8'h00, 8'h00};
        exp_rx = '{8'hA5, 8'hC7, 8'h3A};
        run_txn(q);
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs_recv[i] !== exp_rx[i]) $display("FAIL read_rx%0d: got %h expected %h", i, obs_recv[i], exp_rx[i]); else passes++;
        end
        checks++; if (rd_log[0] !== 7'd5 || rd_log[1] !== 7'd6) $display("FAIL read_addrs: got %h %h expected 05 06", rd_log[0], rd_log[1]); else passes++;
        checks++; if (wr_log.size() != 0) $display("FAIL read_no_write: got %0d expected 0", wr_log.size()); else passes++;
    endtask

    task automatic test_out_of_range();
        bytes_t q;
        q = {8'h94, 8'hFF};
        run_txn(q);
        checks++; if (wr_log.size() != 0) $display("FAIL oor_no_write: got %0d expected 0", wr_log.size()); else passes++;
        checks++; if (err_flag !== 1'b1) $display("FAIL oor_err_set: got %b expected 1", err_flag); else passes++;
        q = {8'h14, 8'h00};
        run_txn(q);
        checks++; if (err_mid !== 1'b0) $display("FAIL oor_err_cleared: got %b expected 0", err_mid); else passes++;
        checks++; if (obs_recv[1] !== 8'h00) $display("FAIL oor_read_data: got %h expected 00", obs_recv[1]); else passes++;
        checks++; if (rd_log.size() != 0) $display("FAIL oor_no_read: got %0d expected 0", rd_log.size()); else passes++;
        checks++; if (err_flag !== 1'b1) $display("FAIL oor_read_err: got %b expected 1", err_flag); else passes++;
    endtask

    task automatic test_cs_abort();
        bytes_t q;
        obs_recv.delete();
        wr_log.delete();
        cs_n = 1'b0;
        ticks(6);
        send_byte(8'h82);
        rx_byte = 8'h5A;
        ticks(8);
        cs_n = 1'b1;
        ticks(8);
        checks++; if (wr_log.size() != 0) $display("FAIL abort_no_write: got %0d expected 0", wr_log.size()); else passes++;
        checks++; if (busy !== 1'b0 || tx_byte !== STATUS) $display("FAIL abort_idle: got busy=%b tx=%h expected 0 a5", busy, tx_byte); else passes++;
        q = {8'h87, 8'h99};
        run_txn(q);
        checks++; if (wr_log.size() != 1 || wr_log[0] !== {7'd7, 8'h99}) $display("FAIL abort_next_cmd: got n=%0d %h expected 1 %h", wr_log.size(), wr_log[0], {7'd7, 8'h99}); else passes++;
    endtask

    // Last data byte completes on the same CLK that chip select rises.
    task automatic test_byte_with_cs_rise();
        wr_log.delete();
        cs_n = 1'b0;
        ticks(6);
        send_byte(8'h8A);
        rx_byte = 8'h6D;
        ticks(16);
        byte_done = 1'b1;
        cs_n = 1'b1;
        ticks(10);
        byte_done = 1'b0;
        ticks(4);
        checks++; if (wr_log.size() != 1 || wr_log[0] !== {7'd10, 8'h6D}) $display("FAIL cs_byte_write: got n=%0d %h expected 1 %h", wr_log.size(), wr_log[0], {7'd10, 8'h6D}); else passes++;
        checks++; if (busy !== 1'b0 || tx_byte !== STATUS) $display("FAIL cs_byte_idle: got busy=%b tx=%h expected 0 a5", busy, tx_byte); else passes++;
    endtask

    task automatic test_random();
        bytes_t      q;
        logic [7:0]  exp_recv[$];
        logic [14:0] exp_wr[$];
        logic [6:0]  exp_rd[$];
        logic [6:0]  a;
        logic        is_wr;
        logic        exp_err;
        int          n;
        for (int i = 0; i < NUM_REGS; i++) begin
            regfile[i]    = 8'($urandom);
            model_regs[i] = regfile[i];
        end
        for (int t = 0; t < 24; t++) begin
            q.delete(); exp_recv.delete(); exp_wr.delete(); exp_rd.delete();
            n     = $urandom_range(1, 5);
            is_wr = 1'($urandom_range(0, 1));
            a     = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(NUM_REGS, 127)) : 7'($urandom_range(0, NUM_REGS - 1));
            q.push_back({is_wr, a});
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            // Expected behaviour of the whole transaction.
            exp_err = 1'b0;
            exp_recv.push_back(STATUS);
            for (int k = 1; k <= n; k++) begin
                if (is_wr) begin
                    exp_recv.push_back(STATUS);
                    if (int'(a) < NUM_REGS) begin
                        exp_wr.push_back({a, q[k]});
                        model_regs[a[3:0]] = q[k];
                    end else begin
                        exp_err = 1'b1;
                    end
                end else if (int'(a) < NUM_REGS) begin
                    exp_recv.push_back(model_regs[a[3:0]]);
                    exp_rd.push_back(a);
                end else begin
                    exp_recv.push_back(8'h00);
                    exp_err = 1'b1;
                end
                a = model_next(a);
            end
            // The final byte boundary of a read still prefetches one more.
            if (!is_wr) begin
                if (int'(a) < NUM_REGS) exp_rd.push_back(a);
                else exp_err = 1'b1;
            end
            run_txn(q);
            for (int k = 0; k <= n; k++) begin
                checks++; if (obs_recv[k] !== exp_recv[k]) $display("FAIL rand%0d_rx%0d: got %h expected %h", t, k, obs_recv[k], exp_recv[k]); else passes++;
            end
            checks++; if (wr_log.size() != exp_wr.size() || rd_log.size() != exp_rd.size()) $display("FAIL rand%0d_counts: got wr=%0d rd=%0d expected wr=%0d rd=%0d", t, wr_log.size(), rd_log.size(), exp_wr.size(), exp_rd.size()); else passes++;
            for (int k = 0; k < exp_wr.size(); k++) begin
                checks++; if (wr_log[k] !== exp_wr[k]) $display("FAIL rand%0d_wr%0d: got %h expected %h", t, k, wr_log[k], exp_wr[k]); else passes++;
            end
            for (int k = 0; k < exp_rd.size(); k++) begin
                checks++; if (rd_log[k] !== exp_rd[k]) $display("FAIL rand%0d_rd%0d: got %h expected %h", t, k, rd_log[k], exp_rd[k]); else passes++;
            end
            checks++; if (err_flag !== exp_err) $display("FAIL rand%0d_err: got %b expected %b", t, err_flag, exp_err); else passes++;
            checks++; if (busy !== 1'b0) $display("FAIL rand%0d_busy: got %b expected 0", t, busy); else passes++;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            checks++; if (regfile[i] !== model_regs[i]) $display("FAIL rand_reg%0d: got %h expected %h", i, regfile[i], model_regs[i]); else passes++;
        end
    endtask

    task automatic test_no_overlap();
        checks++; if (overlap_cnt != 0) $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap_cnt); else passes++;
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        cs_n      = 1'b1;
        byte_done = 1'b0;
        rx_byte   = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) regfile[i] = 8'($urandom);
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        ticks(3);
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_read();
        test_out_of_range();
        test_cs_abort();
        test_byte_with_cs_rise();
        test_random();
        test_no_overlap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
